// File: rtl/clk_phase_div_pkg.sv
// Shared types and constants for the clk_phase_div phase-aligned clock divider.
// Phase-shift state machine encoding and lock-counter width live here.
package clk_phase_div_pkg;

    localparam int LOCK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } ps_state_t;

endpackage

// File: rtl/clk_phase_div_ch.sv
// One divided-clock channel: compares the shared phase counter against this
// channel's offset and registers a 50% duty output.
module clk_phase_div_ch
    import clk_phase_div_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int DIVIDE = 4
) (
    input  logic             clk2x,
    input  logic             resetb,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] off,
    output logic             clk_out
);

    localparam logic [CNT_W:0] DIV_X = (CNT_W+1)'(DIVIDE);
    localparam logic [CNT_W:0] HALF  = (CNT_W+1)'(DIVIDE / 2);

    logic [CNT_W:0] phase_p0;

    // One extra bit so cnt + DIVIDE never overflows when DIVIDE == 2^CNT_W.
    always_comb begin
        if (cnt >= off) begin
            phase_p0 = {1'b0, cnt} - {1'b0, off};
        end else begin
            phase_p0 = {1'b0, cnt} + DIV_X - {1'b0, off};
        end
    end

    // Stage p0 -> p1: registered clock output.
    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            clk_out <= 1'b0;
        end else begin
            clk_out <= (phase_p0 < HALF);
        end
    end

endmodule

// File: rtl/clk_phase_div.sv
// Multi-channel phase-offset clock divider with lock detection.
// Define CLK_PHASE_DIV_PHASE_SHIFT_EN to compile in runtime phase stepping.
module clk_phase_div
    import clk_phase_div_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 4,
    parameter int DIVIDE       = 4,
    parameter int LOCK_PERIODS = 8,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk2x,
    input  logic                    resetb,
    input  logic [NUM_CH*CNT_W-1:0] ph_off,
    input  logic                    ps_en,
    input  logic                    ps_incdec,
    input  logic [CH_W-1:0]         ps_ch,
    output logic                    ps_done,
    output logic [NUM_CH-1:0]       clk_out,
    output logic                    locked
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIVIDE - 1);
    localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_PERIODS);

    logic [CNT_W-1:0]  cnt_p0;
    logic              cnt_wrap;
    logic [LOCK_W-1:0] lock_cnt;
    logic [CNT_W-1:0]  off [NUM_CH];

    function automatic logic [CNT_W-1:0] wrap_mod(input logic [CNT_W-1:0] v);
        return CNT_W'(32'(v) % DIVIDE);
    endfunction

    function automatic logic [CNT_W-1:0] step_off(input logic [CNT_W-1:0] v,
                                                  input logic             inc);
        if (inc) begin
            return (v == CNT_MAX) ? '0 : v + CNT_W'(1);
        end
        return (v == '0) ? CNT_MAX : v - CNT_W'(1);
    endfunction

    assign cnt_wrap = (cnt_p0 == CNT_MAX);

    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            cnt_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_wrap ? '0 : cnt_p0 + CNT_W'(1);
        end
    end

    // Lock after LOCK_PERIODS full output periods; sticky until reset.
    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            if (cnt_wrap && (lock_cnt != LOCK_TGT)) begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
            end
            if (lock_cnt == LOCK_TGT) begin
                locked <= 1'b1;
            end
        end
    end

`ifdef CLK_PHASE_DIV_PHASE_SHIFT_EN
    ps_state_t       ps_state;
    logic [CH_W-1:0] ps_ch_q;
    logic            ps_inc_q;
    logic            ps_apply;

    // Offsets only move at the wrap so no channel sees a runt pulse.
    assign ps_apply = (ps_state == PEND) && cnt_wrap;

    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            ps_state <= IDLE;
            ps_ch_q  <= '0;
            ps_inc_q <= 1'b0;
            ps_done  <= 1'b0;
        end else begin
            case (ps_state)
                IDLE: begin
                    ps_done <= 1'b0;
                    if (ps_en && locked) begin
                        ps_ch_q  <= ps_ch;
                        ps_inc_q <= ps_incdec;
                        ps_state <= PEND;
                    end
                end
                PEND: begin
                    if (cnt_wrap) begin
                        ps_done  <= 1'b1;
                        ps_state <= DONE;
                    end
                end
                DONE: begin
                    ps_done  <= 1'b0;
                    ps_state <= IDLE;
                end
                default: begin
                    ps_done  <= 1'b0;
                    ps_state <= IDLE;
                end
            endcase
        end
    end
`else
    logic unused_ps;

    assign unused_ps = ^{ps_en, ps_incdec, ps_ch};
    assign ps_done   = 1'b0;
`endif

    // Offsets follow ph_off until lock, then hold (or step on request).
    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_CH; i++) begin
                off[i] <= '0;
            end
        end else if (!locked) begin
            for (int i = 0; i < NUM_CH; i++) begin
                off[i] <= wrap_mod(ph_off[i*CNT_W +: CNT_W]);
            end
        end
`ifdef CLK_PHASE_DIV_PHASE_SHIFT_EN
        else if (ps_apply && (int'(ps_ch_q) < NUM_CH)) begin
            off[ps_ch_q] <= step_off(off[ps_ch_q], ps_inc_q);
        end
`endif
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_phase_div_ch #(
            .CNT_W  (CNT_W),
            .DIVIDE (DIVIDE)
        ) u_ch (
            .clk2x   (clk2x),
            .resetb  (resetb),
            .cnt     (cnt_p0),
            .off     (off[i]),
            .clk_out (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_phase_div.sv
// Randomised self-checking bench for clk_phase_div against a cycle-count model.
// Phase-shift expectations follow whether CLK_PHASE_DIV_PHASE_SHIFT_EN is defined.
module tb_clk_phase_div;

    localparam int NUM_CH       = 4;
    localparam int CNT_W        = 4;
    localparam int DIVIDE       = 4;
    localparam int LOCK_PERIODS = 8;
    localparam int CH_W         = 2;
`ifdef CLK_PHASE_DIV_PHASE_SHIFT_EN
    localparam bit PS_EN = 1'b1;
`else
    localparam bit PS_EN = 1'b0;
`endif

    logic                    clk2x = 1'b0;
    logic                    resetb = 1'b0;
    logic [NUM_CH*CNT_W-1:0] ph_off = '0;
    logic                    ps_en = 1'b0;
    logic                    ps_incdec = 1'b0;
    logic [CH_W-1:0]         ps_ch = '0;
    logic                    ps_done;
    logic [NUM_CH-1:0]       clk_out;
    logic                    locked;

    always #5 clk2x = ~clk2x;

    clk_phase_div #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DIVIDE       (DIVIDE),
        .LOCK_PERIODS (LOCK_PERIODS)
    ) dut (
        .clk2x     (clk2x),
        .resetb    (resetb),
        .ph_off    (ph_off),
        .ps_en     (ps_en),
        .ps_incdec (ps_incdec),
        .ps_ch     (ps_ch),
        .ps_done   (ps_done),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: edges since reset release, offsets, and shift bookkeeping.
    int n;
    int moff [NUM_CH];
    bit m_locked;
    bit pend;
    int pend_ch;
    bit pend_inc;
    int last_apply;
    int done_seen;

    task automatic model_reset();
        n          = 0;
        m_locked   = 1'b0;
        pend       = 1'b0;
        last_apply = -100;
        for (int i = 0; i < NUM_CH; i++) moff[i] = 0;
    endtask

    task automatic cycle();
        int                prev_cnt;
        bit                acc;
        logic [NUM_CH-1:0] exp_clk;
        bit                exp_done;
        @(posedge clk2x);
        n++;
        prev_cnt = (n - 1) % DIVIDE;
        for (int i = 0; i < NUM_CH; i++)
            exp_clk[i] = ((((prev_cnt - moff[i]) % DIVIDE) + DIVIDE) % DIVIDE) < (DIVIDE / 2);
        acc = PS_EN && ps_en && m_locked && !pend && (n != last_apply + 1);
        if (!m_locked) begin
            for (int i = 0; i < NUM_CH; i++) moff[i] = int'(ph_off[i*CNT_W +: CNT_W]) % DIVIDE;
        end else if (pend && (n % DIVIDE == 0)) begin
            if (pend_ch < NUM_CH)
                moff[pend_ch] = pend_inc ? (moff[pend_ch] + 1) % DIVIDE
                                         : (moff[pend_ch] + DIVIDE - 1) % DIVIDE;
            pend       = 1'b0;
            last_apply = n;
        end
        if (acc) begin
            pend     = 1'b1;
            pend_ch  = int'(ps_ch);
            pend_inc = ps_incdec;
        end
        exp_done = (n == last_apply);
        m_locked = (n >= LOCK_PERIODS * DIVIDE + 1);
        #1;
        if (ps_done === 1'b1) done_seen++;
        check("clk_out", 32'(clk_out), 32'(exp_clk));
        check("locked", 32'(locked), 32'(m_locked));
        check("ps_done", 32'(ps_done), 32'(exp_done));
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) cycle();
    endtask

    task automatic shift(input int ch, input bit inc);
        ps_en     = 1'b1;
        ps_ch     = CH_W'(ch);
        ps_incdec = inc;
        cycle();
        ps_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_ps_done"}, 32'(ps_done), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk2x);
        #1;
        resetb = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk2x);
        #1;
        check_reset_outputs("por");
        release_reset();
        run(45);

        // Quadrature offsets, then single and wrapping steps.
        resetb = 1'b0;
        #1;
        check_reset_outputs("rst2");
        ph_off = {4'd3, 4'd2, 4'd1, 4'd0};
        release_reset();
        run(40);
        shift(1, 1'b1);
        run(10);

        done_seen = 0;
        shift(0, 1'b0);
        shift(0, 1'b0);
        run(10);
        check("single_done", 32'(done_seen), PS_EN ? 32'd1 : 32'd0);

        // Abort a pending shift with an asynchronous reset.
        shift(2, 1'b1);
        #1;
        resetb = 1'b0;
        #1;
        check_reset_outputs("abort");
        ph_off = 16'($urandom);
        repeat (2) @(posedge clk2x);
        release_reset();
        done_seen = 0;
        run(45);
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Random epochs: ph_off wiggles before and after lock, random shift requests.
        for (int ep = 0; ep < 3; ep++) begin
            resetb = 1'b0;
            #1;
            check_reset_outputs("rand_rst");
            ph_off = 16'($urandom);
            release_reset();
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(19, 0) == 0) ph_off = 16'($urandom);
                ps_en     = ($urandom_range(5, 0) == 0);
                ps_ch     = CH_W'($urandom);
                ps_incdec = 1'($urandom);
                cycle();
            end
            ps_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
